// File: rtl/dispatch_demux_1to3_pkg.sv
// ----------------------------------------------------------------------------
// dispatch_demux_1to3_pkg
//
// Purpose: shared constants for the 1-to-3 dispatch demultiplexer: default
//          word width, default select width, channel count and the channel
//          index encoding used on in_sel.
//
// Contents:
//   DEFAULT_WORD_SIZE  default data width of every channel
//   DEFAULT_SEL_W      default width of the destination select field
//   NUM_CH             number of real output channels (a, b, c)
//   ch_e               channel index encoding (CH_A..CH_C, CH_ILLEGAL)
// ----------------------------------------------------------------------------
package dispatch_demux_1to3_pkg;

    localparam int DEFAULT_WORD_SIZE = 8;
    localparam int DEFAULT_SEL_W     = 2;
    localparam int NUM_CH            = 3;

    // Destination encoding carried on in_sel. CH_ILLEGAL is accepted and
    // discarded by the demux; it never reaches a slot.
    typedef enum logic [1:0] {
        CH_A       = 2'd0,
        CH_B       = 2'd1,
        CH_C       = 2'd2,
        CH_ILLEGAL = 2'd3
    } ch_e;

endpackage

// File: rtl/dispatch_demux_1to3_slot.sv
// ----------------------------------------------------------------------------
// demux_slot
//
// Purpose: one-entry registered output slot (data register plus valid bit)
//          with ready/valid handshake on the consumer side. A fill and a
//          drain in the same cycle keep the slot full and load the new word,
//          so a continuously-ready consumer sees back-to-back words.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset (clears valid and data)
//   fill       in   load fill_data into the slot at the next edge
//   fill_data  in   word to load
//   out_ready  in   consumer accepts the slot word this cycle
//   out_valid  out  slot holds a word
//   out_data   out  registered slot word (holds last value after a drain)
//   slot_free  out  slot can take a word this cycle (empty or draining)
// ----------------------------------------------------------------------------
module demux_slot #(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fill,
    input  logic [WORD_SIZE-1:0] fill_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 slot_free
);

    logic                 valid_q;
    logic                 valid_d;
    logic [WORD_SIZE-1:0] data_q;
    logic [WORD_SIZE-1:0] data_d;

    // Free when empty, or when the current word leaves at this edge.
    assign slot_free = ~valid_q | out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (fill) begin
            // A fill wins over a drain: the slot stays valid with the new word.
            valid_d = 1'b1;
            data_d  = fill_data;
        end else if (valid_q && out_ready) begin
            // Drain without fill: only valid drops, data keeps its value.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/dispatch_demux_1to3.sv
// ----------------------------------------------------------------------------
// dispatch_demux_1to3
//
// Purpose: routes words from one producer to one of three independent
//          consumer channels (a, b, c) selected by in_sel. Each channel owns
//          a one-entry slot, so a stalled channel never blocks the others.
//          in_sel = 3 is an illegal destination: the word is accepted and
//          dropped.
//
// Configuration macro:
//   DISPATCH_ERR_EN  when defined, adds the err output: a sticky flag set by
//                    any accepted illegal-select word, cleared only by reset.
//                    When undefined, the err port and register do not exist.
//
// Ports:
//   clk                         in   clock, rising edge
//   reset                       in   synchronous active-high reset
//   in_data   [WORD_SIZE]       in   producer word
//   in_sel    [SEL_W]           in   destination 0->a, 1->b, 2->c, else illegal
//   in_valid                    in   producer offers a word
//   in_ready                    out  word accepted this cycle (combinational)
//   out_{a,b,c}_data            out  registered channel words
//   out_{a,b,c}_valid           out  channel slot holds a word
//   out_{a,b,c}_ready           in   consumer accepts the channel word
//   err                         out  sticky illegal-select flag (optional)
// ----------------------------------------------------------------------------
module dispatch_demux_1to3
    import dispatch_demux_1to3_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int SEL_W     = DEFAULT_SEL_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_SIZE-1:0] out_a_data,
    output logic [WORD_SIZE-1:0] out_b_data,
    output logic [WORD_SIZE-1:0] out_c_data,
    output logic                 out_a_valid,
    output logic                 out_b_valid,
    output logic                 out_c_valid,
    input  logic                 out_a_ready,
    input  logic                 out_b_ready,
    input  logic                 out_c_ready
`ifdef DISPATCH_ERR_EN
    ,
    output logic                 err
`endif
);

    logic [NUM_CH-1:0]    sel_hit;
    logic [NUM_CH-1:0]    slot_free;
    logic [NUM_CH-1:0]    slot_fill;
    logic [NUM_CH-1:0]    slot_ready;
    logic [NUM_CH-1:0]    slot_valid;
    logic [WORD_SIZE-1:0] slot_data [NUM_CH];
    logic                 sel_legal;

    assign slot_ready = {out_c_ready, out_b_ready, out_a_ready};

    // Select decode and per-channel slots. Any select value outside the
    // channel range (3, or larger when SEL_W is widened) hits no slot.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign sel_hit[gi] = (in_sel == SEL_W'(gi));

            // Fill only the selected slot, and only when it can take the word.
            // The fill is independent of reset: the slot's reset overrides it.
            assign slot_fill[gi] = in_valid & sel_hit[gi] & slot_free[gi];

            demux_slot #(
                .WORD_SIZE (WORD_SIZE)
            ) u_slot (
                .clk       (clk),
                .reset     (reset),
                .fill      (slot_fill[gi]),
                .fill_data (in_data),
                .out_ready (slot_ready[gi]),
                .out_valid (slot_valid[gi]),
                .out_data  (slot_data[gi]),
                .slot_free (slot_free[gi])
            );
        end
    endgenerate

    assign sel_legal = |sel_hit;

    // in_ready depends only on in_sel, slot state and the channel readies,
    // never on in_valid. Illegal selects are always consumed.
    assign in_ready = sel_legal ? |(sel_hit & slot_free) : 1'b1;

    assign out_a_data  = slot_data[CH_A];
    assign out_b_data  = slot_data[CH_B];
    assign out_c_data  = slot_data[CH_C];
    assign out_a_valid = slot_valid[CH_A];
    assign out_b_valid = slot_valid[CH_B];
    assign out_c_valid = slot_valid[CH_C];

`ifdef DISPATCH_ERR_EN
    logic err_q;
    logic err_d;

    // An illegal word is always accepted (in_ready=1), so in_valid alone
    // marks the acceptance.
    always_comb begin
        err_d = err_q;
        if (in_valid && !sel_legal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_dispatch_demux_1to3.sv
// ----------------------------------------------------------------------------
// tb_dispatch_demux_1to3
//
// Directed scenarios followed by randomized traffic with random back-pressure.
// The reference model is a per-channel FIFO of accepted words plus the last
// word loaded into each channel; a monitor process compares the DUT against
// it every cycle. Build with DISPATCH_ERR_EN defined to also check err.
// ----------------------------------------------------------------------------
module tb_dispatch_demux_1to3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_a_data, out_b_data, out_c_data;
    logic       out_a_valid, out_b_valid, out_c_valid;
    logic       out_a_ready, out_b_ready, out_c_ready;
`ifdef DISPATCH_ERR_EN
    logic       err;
`endif

    always #5 clk = ~clk;

    dispatch_demux_1to3 #(
        .WORD_SIZE (8),
        .SEL_W     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_a_data  (out_a_data),
        .out_b_data  (out_b_data),
        .out_c_data  (out_c_data),
        .out_a_valid (out_a_valid),
        .out_b_valid (out_b_valid),
        .out_c_valid (out_c_valid),
        .out_a_ready (out_a_ready),
        .out_b_ready (out_b_ready),
        .out_c_ready (out_c_ready)
`ifdef DISPATCH_ERR_EN
        ,
        .err         (err)
`endif
    );

    int         total = 0;
    int         bad   = 0;
    bit         mon_en  = 1'b0;
    bit         verbose = 1'b1;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qc[$];
    logic [7:0] last_d [3] = '{8'h00, 8'h00, 8'h00};
    bit         err_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- model helpers ----------------
    function automatic int qsize(input int ch);
        case (ch)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic logic [7:0] qfront(input int ch);
        case (ch)
            0:       return qa[0];
            1:       return qb[0];
            default: return qc[0];
        endcase
    endfunction

    task automatic qpop(input int ch);
        case (ch)
            0:       void'(qa.pop_front());
            1:       void'(qb.pop_front());
            default: void'(qc.pop_front());
        endcase
    endtask

    task automatic qpush(input int ch, input logic [7:0] d);
        case (ch)
            0:       qa.push_back(d);
            1:       qb.push_back(d);
            default: qc.push_back(d);
        endcase
    endtask

    function automatic logic dut_vld(input int ch);
        case (ch)
            0:       return out_a_valid;
            1:       return out_b_valid;
            default: return out_c_valid;
        endcase
    endfunction

    function automatic logic [7:0] dut_dat(input int ch);
        case (ch)
            0:       return out_a_data;
            1:       return out_b_data;
            default: return out_c_data;
        endcase
    endfunction

    function automatic logic dut_rdy(input int ch);
        case (ch)
            0:       return out_a_ready;
            1:       return out_b_ready;
            default: return out_c_ready;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    // Samples 2 time units after the falling edge (inputs settled), compares
    // the pre-edge state against the model, then retires words that the
    // upcoming rising edge will deliver.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                for (int ch = 0; ch < 3; ch++) begin
                    check($sformatf("ch%0d_valid", ch), 32'(dut_vld(ch)), 32'(qsize(ch) > 0));
                    if (qsize(ch) > 0)
                        check($sformatf("ch%0d_data", ch), 32'(dut_dat(ch)), 32'(qfront(ch)));
                    else
                        check($sformatf("ch%0d_held_data", ch), 32'(dut_dat(ch)), 32'(last_d[ch]));
                end
                if (in_sel == 2'd3)
                    check("in_ready_illegal", 32'(in_ready), 32'd1);
                else
                    check("in_ready", 32'(in_ready),
                          32'((qsize(int'(in_sel)) == 0) || dut_rdy(int'(in_sel))));
`ifdef DISPATCH_ERR_EN
                check("err", 32'(err), 32'(err_exp));
`endif
                for (int ch = 0; ch < 3; ch++) begin
                    if (qsize(ch) > 0 && dut_rdy(ch)) begin
                        if (verbose)
                            $display("deliver ch%0d data=%02h", ch, qfront(ch));
                        qpop(ch);
                    end
                end
                if (reset) begin
                    qa.delete();
                    qb.delete();
                    qc.delete();
                    last_d  = '{8'h00, 8'h00, 8'h00};
                    err_exp = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Drives one cycle of inputs on the falling edge; returns 3 units later,
    // before the rising edge, after recording any accepted word.
    task automatic drive(input bit rst, input bit v, input logic [1:0] s, input logic [7:0] d,
                         input bit ra, input bit rb, input bit rc);
        @(negedge clk);
        reset       = rst;
        in_valid    = v;
        in_sel      = s;
        in_data     = d;
        out_a_ready = ra;
        out_b_ready = rb;
        out_c_ready = rc;
        #3;
        if (!rst && v && in_ready === 1'b1) begin
            if (s != 2'd3) begin
                qpush(int'(s), d);
                last_d[int'(s)] = d;
            end else begin
`ifdef DISPATCH_ERR_EN
                err_exp = 1'b1;
`endif
            end
            if (verbose)
                $display("accept sel=%0d data=%02h", s, d);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00;
        out_a_ready = 1'b0; out_b_ready = 1'b0; out_c_ready = 1'b0;

        drive(1, 0, 2'd0, 8'h00, 0, 0, 0);
        drive(1, 0, 2'd0, 8'h00, 0, 0, 0);
        mon_en = 1'b1;

        // Reset state and in_ready right after reset.
        drive(0, 0, 2'd0, 8'h00, 0, 0, 0);
        check("rst_a_valid", 32'(out_a_valid), 32'd0);
        check("rst_b_valid", 32'(out_b_valid), 32'd0);
        check("rst_c_valid", 32'(out_c_valid), 32'd0);
        check("rst_a_data",  32'(out_a_data), 32'h0);
        check("rst_ready_s0", 32'(in_ready), 32'd1);
        drive(0, 0, 2'd1, 8'h00, 0, 0, 0);
        check("rst_ready_s1", 32'(in_ready), 32'd1);
        drive(0, 0, 2'd2, 8'h00, 0, 0, 0);
        check("rst_ready_s2", 32'(in_ready), 32'd1);

        // Word to channel b appears one cycle later, others untouched.
        drive(0, 1, 2'd1, 8'hA5, 0, 0, 0);
        check("b_accept", 32'(in_ready), 32'd1);
        drive(0, 0, 2'd0, 8'h00, 0, 1, 0);
        check("b_valid", 32'(out_b_valid), 32'd1);
        check("b_data",  32'(out_b_data), 32'hA5);
        check("b_a_valid", 32'(out_a_valid), 32'd0);
        check("b_c_valid", 32'(out_c_valid), 32'd0);

        // Stalled channel a blocks only its own traffic.
        drive(0, 1, 2'd0, 8'h11, 0, 0, 0);
        drive(0, 1, 2'd0, 8'h44, 0, 0, 0);
        check("a_full_ready", 32'(in_ready), 32'd0);
        drive(0, 1, 2'd2, 8'h33, 0, 0, 0);
        check("c_bypass_ready", 32'(in_ready), 32'd1);
        drive(0, 0, 2'd0, 8'h00, 0, 0, 0);
        check("c_valid", 32'(out_c_valid), 32'd1);
        check("c_data",  32'(out_c_data), 32'h33);
        check("a_stall_data", 32'(out_a_data), 32'h11);

        // Simultaneous drain and fill of slot a, no bubble.
        drive(0, 1, 2'd0, 8'h22, 1, 0, 1);
        check("a_refill_ready", 32'(in_ready), 32'd1);
        drive(0, 0, 2'd0, 8'h00, 0, 0, 0);
        check("a_refill_valid", 32'(out_a_valid), 32'd1);
        check("a_refill_data",  32'(out_a_data), 32'h22);
        check("c_drained_valid", 32'(out_c_valid), 32'd0);
        check("c_drained_data",  32'(out_c_data), 32'h33);

        // Illegal select is consumed and dropped.
        drive(0, 1, 2'd3, 8'h77, 0, 0, 0);
        check("ill_ready", 32'(in_ready), 32'd1);
        drive(0, 0, 2'd0, 8'h00, 0, 0, 0);
        check("ill_a_data",  32'(out_a_data), 32'h22);
        check("ill_b_valid", 32'(out_b_valid), 32'd0);
        check("ill_c_valid", 32'(out_c_valid), 32'd0);
`ifdef DISPATCH_ERR_EN
        check("ill_err", 32'(err), 32'd1);
        drive(0, 0, 2'd0, 8'h00, 0, 0, 0);
        check("ill_err_sticky", 32'(err), 32'd1);
`endif

        // Reset overrides a same-cycle fill; all slots empty afterwards.
        drive(0, 1, 2'd1, 8'h55, 0, 0, 0);
        drive(0, 1, 2'd2, 8'h66, 0, 0, 0);
        drive(1, 1, 2'd1, 8'h99, 0, 1, 0);
        drive(0, 0, 2'd0, 8'h00, 0, 0, 0);
        check("rst2_a_valid", 32'(out_a_valid), 32'd0);
        check("rst2_b_valid", 32'(out_b_valid), 32'd0);
        check("rst2_c_valid", 32'(out_c_valid), 32'd0);
        check("rst2_b_data",  32'(out_b_data), 32'h0);
        check("rst2_c_data",  32'(out_c_data), 32'h0);
`ifdef DISPATCH_ERR_EN
        check("rst2_err", 32'(err), 32'd0);
`endif
        drive(0, 0, 2'd0, 8'h00, 0, 0, 0);
        check("rst2_b_never", 32'(out_b_valid), 32'd0);

        // Random traffic with random back-pressure and rare resets.
        verbose = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 999) == 0,
                  $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)),
                  8'($urandom),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) != 0,
                  $urandom_range(0, 4) == 0);
        end
        for (int i = 0; i < 4; i++)
            drive(0, 0, 2'd0, 8'h00, 1, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
